// File: rtl/dsp_bist_pkg.sv
// Shared definitions for the DSP BIST sequencer: FSM state encodings,
// LFSR feedback polynomial, per-mode gap lookup and test-index decode.
package dsp_bist_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_REPORT = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Galois taps for a right-shifting 32-bit maximal-length LFSR.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Idle cycles between start pulses for a given DSP mode.
    function automatic int gap_of(input logic [1:0] m, input int g0, input int g1, input int g2);
        case (m)
            2'd0:    return g0;
            2'd1:    return g1;
            default: return g2;
        endcase
    endfunction

    // Test t sweeps mac fastest, then mode, then pipe depth.
    function automatic logic [1:0] test_mode(input int t);
        return 2'((t % 6) / 2);
    endfunction

    function automatic logic test_mac(input int t);
        return 1'(t % 2);
    endfunction

    function automatic int test_pipe(input int t);
        return t / 6;
    endfunction

endpackage

// File: rtl/dsp_bist_lfsr.sv
// Seedable 32-bit Galois LFSR; load restores the seed, step advances once.
module dsp_bist_lfsr
    import dsp_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    // Seed on reset or load; otherwise shift right with feedback from bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'd0);
        end
    end

endmodule

// File: rtl/dsp_bist_seq.sv
// BIST sequencer: sweeps every pipe/mode/mac combination of the fracturable
// DSP, feeds DUT and reference model identical pseudo-random operands and
// reports a saturating mismatch count per test.
module dsp_bist_seq
    import dsp_bist_pkg::*;
#(
    parameter int          WIDTH            = 16,
    parameter int          PIPE_STAGE_WIDTH = 1,
    parameter int          NUM_PIPE         = 2,
    parameter int          TEST_COUNT       = 200,
    parameter int          SETTLE_CYCLES    = 10,
    parameter int          DRAIN_CYCLES     = 10,
    parameter int          GAP_M0           = 0,
    parameter int          GAP_M1           = 1,
    parameter int          GAP_M2           = 3,
    parameter int          ERR_WIDTH        = 16,
    parameter logic [31:0] SEED             = 32'hACE1_1234
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bist_go,
    input  logic [2*WIDTH-1:0]            dut_out,
    input  logic [2*WIDTH-1:0]            model_out,
    input  logic                          compare_res,
    output logic                          start,
    output logic [1:0]                    mode,
    output logic                          mac,
    output logic [PIPE_STAGE_WIDTH-1:0]   pipe_stages,
    output logic [WIDTH-1:0]              aa,
    output logic [WIDTH-1:0]              bb,
    output logic [2*WIDTH-1:0]            cc,
    output logic                          busy,
    output logic                          result_valid,
    output logic [$clog2(6*NUM_PIPE)-1:0] result_idx,
    output logic [ERR_WIDTH-1:0]          result_err,
    output logic [6*NUM_PIPE-1:0]         pass_vec,
    output logic                          done,
    output logic                          all_pass
);

    localparam int NTEST = 6 * NUM_PIPE;
    localparam int IDX_W = $clog2(NTEST);
    localparam int H     = WIDTH / 2;
    localparam int ISS_W = $clog2(TEST_COUNT + 1);
    localparam int CNT_W = 16;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [ISS_W-1:0]     iss_q;
    logic [IDX_W-1:0]     t_q;
    logic [ERR_WIDTH-1:0] err_q;
    logic [31:0]          lfsr_q;
    logic [CNT_W-1:0]     gap_len;
    logic [NTEST-1:0]     pass_upd;
    logic                 go_ok, enter_setup, load_op, last_test, count_en, err_hit;
    int                   t_set;

    // Sign-extend an (H+1)-bit slice to the full operand width.
    function automatic logic [WIDTH-1:0] narrow_ext(input logic [H:0] v);
        logic signed [WIDTH-1:0] ext;
        ext = {{(WIDTH-H-1){v[H]}}, v};
        return ext;
    endfunction

    function automatic logic [WIDTH-1:0] op_a(input logic [1:0] m, input logic [31:0] r);
        if (m[1]) return r[WIDTH-1:0];
        return narrow_ext(r[H:0]);
    endfunction

    function automatic logic [WIDTH-1:0] op_b(input logic [1:0] m, input logic [31:0] r);
        if (m == 2'd0) return narrow_ext(r[31:31-H]);
        return r[31 -: WIDTH];
    endfunction

    dsp_bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (go_ok),
        .step  (load_op),
        .state (lfsr_q)
    );

    assign go_ok       = bist_go && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_test   = (t_q == IDX_W'(NTEST - 1));
    assign gap_len     = CNT_W'(gap_of(mode, GAP_M0, GAP_M1, GAP_M2));
    assign count_en    = (state_q == ST_ISSUE) || (state_q == ST_GAP) || (state_q == ST_DRAIN);
    assign err_hit     = compare_res && (dut_out != model_out);
    assign enter_setup = (state_d == ST_SETUP) && (state_q != ST_SETUP);
    // Every cycle spent in ISSUE, including back-to-back ones, gets fresh operands.
    assign load_op     = (state_d == ST_ISSUE);
    assign t_set       = go_ok ? 0 : int'(t_q) + 1;

    assign start        = (state_q == ST_ISSUE);
    assign result_valid = (state_q == ST_REPORT);
    assign result_idx   = result_valid ? t_q : '0;
    assign result_err   = result_valid ? err_q : '0;
    assign cc           = '0;

    // Next-state decode for the sweep FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bist_go) state_d = ST_SETUP;
            ST_SETUP:  if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (gap_len != '0)                             state_d = ST_GAP;
                else if (iss_q + ISS_W'(1) == ISS_W'(TEST_COUNT)) state_d = ST_DRAIN;
            end
            ST_GAP: begin
                if (cnt_q == gap_len - CNT_W'(1))
                    state_d = (iss_q == ISS_W'(TEST_COUNT)) ? ST_DRAIN : ST_ISSUE;
            end
            ST_DRAIN:  if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = ST_REPORT;
            ST_REPORT: state_d = last_test ? ST_DONE : ST_SETUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pass vector as it will look once the current report is folded in.
    always_comb begin
        pass_upd      = pass_vec;
        pass_upd[t_q] = (err_q == '0);
    end

    // State, dwell counter, issue counter, test index and saturating error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            iss_q   <= '0;
            t_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if (enter_setup) begin
                iss_q <= '0;
                err_q <= '0;
                t_q   <= IDX_W'(t_set);
            end else begin
                if (state_q == ST_ISSUE) iss_q <= iss_q + ISS_W'(1);
                if (count_en && err_hit && err_q != ERR_MAX) err_q <= err_q + ERR_WIDTH'(1);
            end
        end
    end

    // Registered DSP configuration and sweep status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= '0;
            mac         <= 1'b0;
            pipe_stages <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            all_pass    <= 1'b0;
            pass_vec    <= '0;
        end else begin
            if (enter_setup) begin
                mode        <= test_mode(t_set);
                mac         <= test_mac(t_set);
                pipe_stages <= PIPE_STAGE_WIDTH'(test_pipe(t_set));
            end
            if (go_ok) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                all_pass <= 1'b0;
                pass_vec <= '0;
            end
            if (state_q == ST_REPORT) begin
                pass_vec <= pass_upd;
                if (last_test) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    all_pass <= &pass_upd;
                end
            end
        end
    end

    // Operands are captured at each issue and held through the gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aa <= '0;
            bb <= '0;
        end else if (load_op) begin
            aa <= op_a(mode, lfsr_q);
            bb <= op_b(mode, lfsr_q);
        end
    end

endmodule

// File: tb/tb_dsp_bist_seq.sv
// Directed bench for dsp_bist_seq: clean, fault-injected, gated, saturating
// and reset/re-run sweeps with hand-derived expectations.
`timescale 1ns/1ps
module tb_dsp_bist_seq;

    localparam int          W         = 16;
    localparam int          NT        = 12;
    localparam int          TC        = 200;
    localparam int          DRAIN     = 10;
    localparam logic [31:0] SEED      = 32'hACE1_1234;
    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam int          FAULT_ERR = TC * 2 + DRAIN;  // mode 1: issue + 1 gap cycle each, then drain
    localparam int          SC_CLEAN  = 0;
    localparam int          SC_FAULT  = 1;
    localparam int          SC_GATED  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bist_go = 1'b0;
    logic go2 = 1'b0;
    logic [31:0] cyc = '0;
    int scen = SC_CLEAN;
    int errors = 0;
    int checks = 0;

    logic [2*W-1:0] model_out, dut_out, dut_out2;
    logic           compare_res;

    logic           start, mac, busy, result_valid, done, all_pass;
    logic [1:0]     mode;
    logic [0:0]     pipe_stages;
    logic [W-1:0]   aa, bb;
    logic [2*W-1:0] cc;
    logic [3:0]     result_idx;
    logic [15:0]    result_err;
    logic [NT-1:0]  pass_vec;

    logic           start2, mac2, busy2, result_valid2, done2, all_pass2;
    logic [1:0]     mode2;
    logic [0:0]     pipe2;
    logic [W-1:0]   aa2, bb2;
    logic [2*W-1:0] cc2;
    logic [2:0]     result_idx2;
    logic [3:0]     result_err2;
    logic [5:0]     pass_vec2;

    always #5 clk = ~clk;

    assign model_out   = {cyc[15:0] ^ 16'hA5C3, cyc[15:0]};
    assign dut_out     = (scen == SC_CLEAN) ? model_out :
                         (scen == SC_FAULT) ? (model_out ^ ((mode == 2'd1 && mac && pipe_stages == 1'b0) ? 32'd1 : 32'd0)) :
                         ~model_out;
    assign compare_res = (scen != SC_GATED);
    assign dut_out2    = ~model_out;

    dsp_bist_seq dut (
        .clk(clk), .rst(rst), .bist_go(bist_go),
        .dut_out(dut_out), .model_out(model_out), .compare_res(compare_res),
        .start(start), .mode(mode), .mac(mac), .pipe_stages(pipe_stages),
        .aa(aa), .bb(bb), .cc(cc), .busy(busy),
        .result_valid(result_valid), .result_idx(result_idx), .result_err(result_err),
        .pass_vec(pass_vec), .done(done), .all_pass(all_pass)
    );

    dsp_bist_seq #(.NUM_PIPE(1), .TEST_COUNT(16), .SETTLE_CYCLES(2), .DRAIN_CYCLES(4), .ERR_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .bist_go(go2),
        .dut_out(dut_out2), .model_out(model_out), .compare_res(1'b1),
        .start(start2), .mode(mode2), .mac(mac2), .pipe_stages(pipe2),
        .aa(aa2), .bb(bb2), .cc(cc2), .busy(busy2),
        .result_valid(result_valid2), .result_idx(result_idx2), .result_err(result_err2),
        .pass_vec(pass_vec2), .done(done2), .all_pass(all_pass2)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] exp_a(input logic [31:0] r, input int m);
        if (m == 2) return r[15:0];
        return {{7{r[8]}}, r[8:0]};
    endfunction

    function automatic logic [W-1:0] exp_b(input logic [31:0] r, input int m);
        if (m == 0) return {{7{r[31]}}, r[31:23]};
        return r[31:16];
    endfunction

    function automatic int spacing_of(input int m);
        return (m == 0) ? 1 : (m == 1) ? 2 : 4;
    endfunction

    // Per-sweep recorder for the main instance.
    int          rep_n = 0, pulses = 0, smin = 1000, smax = 0, op_n = 0, op_err = 0;
    logic [31:0] last_start = '0;
    logic        have_last = 1'b0, busy_d = 1'b0;
    logic [31:0] mdl_s = SEED;
    logic [W-1:0] fa [2];
    logic [W-1:0] fb [2];
    logic [1:0]  cur_mode = '0;
    logic        cur_mac = 1'b0, cur_pipe = 1'b0;
    int          rec_idx [NT];
    int          rec_err [NT];
    int          rec_pulses [NT];
    int          rec_smin [NT];
    int          rec_smax [NT];
    logic [1:0]  rec_mode [NT];
    logic        rec_mac [NT];
    logic        rec_pipe [NT];

    // Sample away from the active edge; log starts, spacing, operands and reports.
    always @(negedge clk) begin
        cyc    <= cyc + 32'd1;
        busy_d <= busy;
        if (rst) begin
            rep_n <= 0; pulses <= 0; have_last <= 1'b0; op_n <= 0; op_err <= 0;
            mdl_s <= SEED; smin <= 1000; smax <= 0;
        end else begin
            if (busy && !busy_d) begin
                rep_n <= 0; pulses <= 0; have_last <= 1'b0; op_n <= 0; op_err <= 0;
                mdl_s <= SEED; smin <= 1000; smax <= 0;
            end
            if (start) begin
                pulses <= pulses + 1;
                if (have_last) begin
                    if (int'(cyc - last_start) < smin) smin <= int'(cyc - last_start);
                    if (int'(cyc - last_start) > smax) smax <= int'(cyc - last_start);
                end
                last_start <= cyc;
                have_last  <= 1'b1;
                if (aa !== exp_a(mdl_s, (rep_n % 6) / 2) || bb !== exp_b(mdl_s, (rep_n % 6) / 2))
                    op_err <= op_err + 1;
                if (op_n < 2) begin
                    fa[op_n] <= aa;
                    fb[op_n] <= bb;
                end
                op_n     <= op_n + 1;
                mdl_s    <= lfsr_next(mdl_s);
                cur_mode <= mode;
                cur_mac  <= mac;
                cur_pipe <= pipe_stages[0];
            end
            if (result_valid) begin
                if (rep_n < NT) begin
                    rec_idx[rep_n]    <= int'(result_idx);
                    rec_err[rep_n]    <= int'(result_err);
                    rec_pulses[rep_n] <= pulses;
                    rec_smin[rep_n]   <= smin;
                    rec_smax[rep_n]   <= smax;
                    rec_mode[rep_n]   <= cur_mode;
                    rec_mac[rep_n]    <= cur_mac;
                    rec_pipe[rep_n]   <= cur_pipe;
                end
                rep_n     <= rep_n + 1;
                pulses    <= 0;
                have_last <= 1'b0;
                smin      <= 1000;
                smax      <= 0;
            end
        end
    end

    // Report log for the saturating instance.
    int n2 = 0;
    int rec2 [6];
    always @(negedge clk) begin
        if (result_valid2) begin
            if (n2 < 6) rec2[n2] <= int'(result_err2);
            n2 <= n2 + 1;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk) bist_go = 1'b1;
        @(negedge clk) bist_go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", longint'(done), 1);
    endtask

    task automatic wait_rep(input int n, input int budget);
        int k = 0;
        while (rep_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("report_reached", longint'(rep_n >= n), 1);
    endtask

    task automatic check_sweep(input int fault_t);
        check("report_count", rep_n, NT);
        for (int t = 0; t < NT; t++) begin
            check($sformatf("idx[%0d]", t),     rec_idx[t], t);
            check($sformatf("err[%0d]", t),     rec_err[t], (t == fault_t) ? FAULT_ERR : 0);
            check($sformatf("pulses[%0d]", t),  rec_pulses[t], TC);
            check($sformatf("smin[%0d]", t),    rec_smin[t], spacing_of((t % 6) / 2));
            check($sformatf("smax[%0d]", t),    rec_smax[t], spacing_of((t % 6) / 2));
            check($sformatf("mode[%0d]", t),    longint'(rec_mode[t]), (t % 6) / 2);
            check($sformatf("mac[%0d]", t),     longint'(rec_mac[t]), t % 2);
            check($sformatf("pipe[%0d]", t),    longint'(rec_pipe[t]), t / 6);
        end
    endtask

    task automatic check_operands();
        check("op_model_err", op_err, 0);
        check("op_count", op_n, NT * TC);
        check("aa_first",  longint'(fa[0]), 64'h0034);
        check("bb_first",  longint'(fb[0]), 64'hFF59);
        check("aa_second", longint'(fa[1]), 64'hFF1A);
        check("bb_second", longint'(fb[1]), 64'h00AC);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start", longint'(start), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_pass_vec", longint'(pass_vec), 0);
        check("rst_all_pass", longint'(all_pass), 0);
        check("rst_cfg", longint'({mode, mac, pipe_stages}), 0);
        check("rst_ops", longint'({aa, bb}), 0);
        check("rst_result", longint'({result_valid, result_idx, result_err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Saturation on the narrow-counter instance
        @(negedge clk) go2 = 1'b1;
        @(negedge clk) go2 = 1'b0;
        begin
            int k = 0;
            while (done2 !== 1'b1 && k < 5000) begin
                @(negedge clk);
                k++;
            end
        end
        check("sat_done", longint'(done2), 1);
        check("sat_reports", n2, 6);
        for (int t = 0; t < 6; t++) check($sformatf("sat_err[%0d]", t), rec2[t], 15);
        check("sat_all_pass", longint'(all_pass2), 0);
        check("sat_pass_vec", longint'(pass_vec2), 0);

        // Clean sweep, with a stray go while busy
        scen = SC_CLEAN;
        pulse_go();
        check("go_busy", longint'(busy), 1);
        check("go_done_low", longint'(done), 0);
        check("cc_zero", longint'(cc), 0);
        wait_rep(2, 20000);
        pulse_go();
        wait_done(20000);
        check_sweep(-1);
        check_operands();
        check("clean_pass_vec", longint'(pass_vec), 64'hFFF);
        check("clean_all_pass", longint'(all_pass), 1);
        check("clean_busy", longint'(busy), 0);

        // Fault injected in test 3 only
        scen = SC_FAULT;
        pulse_go();
        check("fault_pass_vec_cleared", longint'(pass_vec), 0);
        check("fault_done_cleared", longint'(done), 0);
        wait_done(20000);
        check_sweep(3);
        check("fault_pass_vec", longint'(pass_vec), 64'hFF7);
        check("fault_all_pass", longint'(all_pass), 0);

        // Mismatches everywhere but compare gated off
        scen = SC_GATED;
        pulse_go();
        wait_done(20000);
        check_sweep(-1);
        check("gated_pass_vec", longint'(pass_vec), 64'hFFF);
        check("gated_all_pass", longint'(all_pass), 1);

        // Reset during test 5, then a full re-run from the same seed
        scen = SC_CLEAN;
        pulse_go();
        wait_rep(5, 20000);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_start", longint'(start), 0);
        check("abort_cfg", longint'({mode, mac, pipe_stages}), 0);
        check("abort_ops", longint'({aa, bb}), 0);
        check("abort_status", longint'({done, all_pass, pass_vec}), 0);
        check("abort_result", longint'({result_valid, result_idx, result_err}), 0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_report", rep_n, 0);
        check("abort_idle_busy", longint'(busy), 0);
        pulse_go();
        wait_done(20000);
        check_sweep(-1);
        check_operands();
        check("rerun_all_pass", longint'(all_pass), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_bist_seq.md
Name: dsp_bist_seq

Overview:
- Synthesizable built-in self-test sequencer for the fracturable DSP (DSP_top) and its reference model (DSP_model).
- Drives both with identical pseudo-random operands through every mode / mac / pipe_stages combination.
- Counts per-test mismatches while the model's compare_res is high, and reports pass/fail per test.
- Successor to the simulation-only sweep: parametrised test count, mode gaps and pipe sweep; adds per-test reporting, error saturation and abort-free restart.

Parameters:
- WIDTH, 16: operand width. Even, 4..32.
- PIPE_STAGE_WIDTH, 1: width of pipe_stages.
- NUM_PIPE, 2: pipe_stages values swept, 0..NUM_PIPE-1. Must be ≤ 2**PIPE_STAGE_WIDTH.
- TEST_COUNT, 200: operand issues per test.
- SETTLE_CYCLES, 10: idle cycles after a mode/mac/pipe change, before the first issue.
- DRAIN_CYCLES, 10: idle cycles after the last issue, before the report.
- GAP_M0, 0 / GAP_M1, 1 / GAP_M2, 3: start-low cycles after each issue, for mode 0 / 1 / 2.
- ERR_WIDTH, 16: error counter width. Saturating.
- SEED, 32'hACE1_1234: LFSR seed. Must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- bist_go  in  1  one-cycle pulse; starts a sweep when idle.
- dut_out  in  2*WIDTH  DSP_top out.
- model_out  in  2*WIDTH  DSP_model out.
- compare_res  in  1  model says the current output is checkable.
- start  out  1  to DUT and model.
- mode  out  2  to DUT and model.
- mac  out  1  to DUT and model.
- pipe_stages  out  PIPE_STAGE_WIDTH  to DUT and model.
- aa, bb  out  WIDTH each  operands.
- cc  out  2*WIDTH  accumulate input. Constant 0.
- busy  out  1  high from the cycle after an accepted bist_go until DONE.
- result_valid  out  1  one-cycle pulse per completed test.
- result_idx  out  clog2(6*NUM_PIPE)  test index of the current report.
- result_err  out  ERR_WIDTH  error count of the current report.
- pass_vec  out  6*NUM_PIPE  bit t set iff test t had zero errors.
- done  out  1  level; high after a full sweep until the next accepted bist_go.
- all_pass  out  1  valid with done; equals &pass_vec.

Behaviour:
- Reset: every output is 0, FSM is IDLE, LFSR = SEED. Reset mid-sweep aborts immediately; no partial report is produced.
- Test order, t = 0..6*NUM_PIPE-1: pipe_stages = t/6, mode = (t%6)/2, mac = t%2.
- mode, mac and pipe_stages are registered. They change only on entry to SETUP.
- FSM states: IDLE, SETUP, ISSUE, GAP, DRAIN, REPORT, DONE.
- IDLE/DONE --bist_go--> SETUP with t = 0. On this transition: pass_vec cleared, done cleared, LFSR reseeded.
- bist_go while busy is ignored.
- SETUP: err_cnt cleared, issue counter cleared. Waits SETUP_CYCLES = SETTLE_CYCLES cycles, then -> ISSUE.
- ISSUE: one cycle with start = 1 and new aa/bb; LFSR steps once; issue counter increments.
  - Next state is GAP if the mode's gap is nonzero.
  - Otherwise ISSUE again, or DRAIN once the issue counter reaches TEST_COUNT.
- GAP: start = 0 for GAP_Mx cycles, then ISSUE, or DRAIN once the issue counter reaches TEST_COUNT.
- DRAIN: DRAIN_CYCLES cycles, then REPORT.
- REPORT: one cycle.
  - result_valid = 1, result_idx = t, result_err = err_cnt; pass_vec[t] = (err_cnt == 0).
  - Then SETUP with t+1, or DONE after the last test.
- DONE: done = 1, busy = 0. all_pass is registered on entry to DONE.
- Error counting: only in ISSUE, GAP and DRAIN.
  - err_cnt increments when compare_res && (dut_out != model_out), using a 4-state-free compare.
  - err_cnt saturates at 2**ERR_WIDTH-1.
- LFSR: 32-bit Galois, polynomial 0x80200003, shift right. The all-zero state is unreachable given a nonzero SEED.
- Operands, with H = WIDTH/2 and r = LFSR value before the step:
  - mode 0: aa = sign-extend of r[H:0] to WIDTH; bb = sign-extend of r[31:31-H] to WIDTH.
  - mode 1: aa as in mode 0; bb = r[31 -: WIDTH].
  - mode 2: aa = r[WIDTH-1:0]; bb = r[31 -: WIDTH].
- aa and bb hold their value while start = 0.
- No start pulse is emitted outside ISSUE.

Decomposition:
- Package dsp_bist_pkg: state enum, LFSR polynomial constant, a gap-lookup function (mode -> GAP), and test-index decode functions.
- Natural sub-module: dsp_bist_lfsr (seedable 32-bit Galois LFSR with load and step enables).

Test Plan:
- Clean compare: loop dut_out = model_out, compare_res = 1, defaults, bist_go.
  - Expect 12 result_valid pulses, idx 0..11, all result_err = 0.
  - Expect pass_vec = 12'hFFF, done = 1, all_pass = 1.
- Sequencing check: count start pulses and measure spacing per test.
  - Expect 200 pulses per test.
  - Expect inter-start spacing of 1 / 2 / 4 cycles in modes 0 / 1 / 2.
  - Expect mode/mac/pipe_stages to follow the t decode.
- Fault injection: force dut_out = model_out ^ 1 during test 3 only, compare_res = 1.
  - Expect result_err(3) = 200 + gap/drain cycles counted; expect pass_vec = 12'hFF7, all_pass = 0.
- Gated compare: dut_out != model_out always, compare_res = 0. Expect all result_err = 0 and all_pass = 1.
- Saturation: ERR_WIDTH = 4 with mismatches every cycle. Expect result_err = 15 for every test.
- Reset and re-run:
  - Assert rst during test 5 -> next cycle all outputs 0 and busy = 0.
  - Re-issue bist_go -> aa/bb sequence identical to the first run (same SEED).
  - bist_go during busy has no effect.
